// File: rtl/maindec_q_pkg.sv
// Shared constants for the queued main decoder: opcodes, control bundle layout, memory size codes.
package maindec_q_pkg;

  localparam int CTRL_W = 13;

  // Bit positions inside the control bundle, MSB first
  localparam int B_REGWRITE    = 12;
  localparam int B_REGDST      = 11;
  localparam int B_ALUSRC      = 10;
  localparam int B_BRANCH      = 9;
  localparam int B_BNE         = 8;
  localparam int B_MEMWRITE    = 7;
  localparam int B_MEMTOREG    = 6;
  localparam int B_JUMP        = 5;
  localparam int B_LINK        = 4;
  localparam int B_ZEXT        = 3;
  localparam int B_MEM_SIZE_HI = 2;
  localparam int B_MEM_SIZE_LO = 1;
  localparam int B_MEM_UNS     = 0;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic       branch;
    logic       bne;
    logic       memwrite;
    logic       memtoreg;
    logic       jump;
    logic       link;
    logic       zext;
    logic [1:0] mem_size;
    logic       mem_uns;
  } ctrl_t;

  // Low opcode bits of loads/stores: 00 byte, 01 half, 11 word
  function automatic logic [1:0] mem_size_of(input logic [1:0] op_lo);
    return op_lo[1] ? MEM_SIZE_WORD : (op_lo[0] ? MEM_SIZE_HALF : MEM_SIZE_BYTE);
  endfunction

endpackage

// File: rtl/maindec_q_if.sv
// Producer/consumer bundle of the queued decoder; slave is the decoder, master drives it.
interface maindec_q_if #(
  parameter int PC_W      = 32,
  parameter int ILL_CNT_W = 8
);
  import maindec_q_pkg::*;

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [PC_W-1:0]      in_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [CTRL_W-1:0]    out_ctrl;
  logic [PC_W-1:0]      out_pc;
  logic [31:0]          out_instr;
  logic                 out_illegal;
  logic [ILL_CNT_W-1:0] ill_cnt;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl, out_pc, out_instr, out_illegal, ill_cnt
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_pc, out_instr, out_illegal, ill_cnt
  );

endinterface

// File: rtl/maindec_q_dec.sv
// Combinational MIPS main decoder: instruction word -> extended control bundle and illegal flag.
module maindec_q_dec
  import maindec_q_pkg::*;
(
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl,
  output logic              illegal
);

  logic [5:0] op;
  ctrl_t      c;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign unused_bits = ^instr[25:0];

  always_comb begin
    c       = '0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.zext     = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.memtoreg = 1'b1;
        c.mem_size = mem_size_of(op[1:0]);
        c.mem_uns  = op[2];
      end
      OP_SB, OP_SH, OP_SW: begin
        c.alusrc   = 1'b1;
        c.memwrite = 1'b1;
        c.mem_size = mem_size_of(op[1:0]);
      end
      OP_BEQ: c.branch = 1'b1;
      OP_BNE: begin
        c.branch = 1'b1;
        c.bne    = 1'b1;
      end
      OP_J:   c.jump = 1'b1;
      OP_JAL: begin
        c.jump     = 1'b1;
        c.link     = 1'b1;
        c.regwrite = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/maindec_q.sv
// Queued main decoder: decodes on push, holds {ctrl, illegal, pc, instr} in a DEPTH-entry FIFO.
// Optional MAINDEC_ILLEGAL_CNT_EN adds a saturating count of pushed illegal opcodes.
module maindec_q
  import maindec_q_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int PC_W      = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  maindec_q_if.slave     bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
    logic [PC_W-1:0]   pc;
    logic [31:0]       instr;
  } entry_t;

  entry_t            storage_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  entry_t            head;

  maindec_q_dec u_dec (
    .instr   (bus.in_instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  // in_ready depends only on occupancy, never on out_ready
  assign push  = bus.in_valid & ~full;
  assign pop   = bus.out_ready & ~empty;

  always_ff @(posedge clk) begin
    if (push) begin
      storage_reg[wr_ptr_reg] <= {dec_ctrl, dec_illegal, bus.in_pc, bus.in_instr};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (bus.flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head = storage_reg[rd_ptr_reg];

  // Head fields are masked while empty so stale storage never leaks out
  assign bus.in_ready    = ~full;
  assign bus.out_valid   = ~empty;
  assign bus.out_ctrl    = empty ? '0 : head.ctrl;
  assign bus.out_pc      = empty ? '0 : head.pc;
  assign bus.out_instr   = empty ? '0 : head.instr;
  assign bus.out_illegal = empty ? 1'b0 : head.illegal;

`ifdef MAINDEC_ILLEGAL_CNT_EN
  logic [ILL_CNT_W-1:0] ill_cnt_reg;

  // Pushes discarded by flush are not counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_cnt_reg <= '0;
    end else if (push && !bus.flush && dec_illegal && !(&ill_cnt_reg)) begin
      ill_cnt_reg <= ill_cnt_reg + 1'b1;
    end
  end

  assign bus.ill_cnt = ill_cnt_reg;
`else
  assign bus.ill_cnt = '0;
`endif

endmodule

// File: tb/tb_maindec_q.sv
// Self-checking bench for maindec_q: directed scenarios plus random traffic against a queue model.
module tb_maindec_q;

  localparam int DEPTH = 2;

`ifdef MAINDEC_ILLEGAL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [12:0] ctrl;
    logic        illegal;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   ref_ill;
  exp_t q[$];

  maindec_q_if #(.PC_W(32), .ILL_CNT_W(8)) bus ();

  maindec_q #(.DEPTH(DEPTH), .PC_W(32), .ILL_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Reference decode from the opcode table, using numeric opcode ranges
  function automatic exp_t ref_dec(input logic [31:0] instr, input logic [31:0] pc);
    int op;
    bit rw, rd, as, br, bn, mw, mr, jp, lk, zx, un, ill;
    logic [1:0] sz;
    exp_t e;
    op = int'(instr[31:26]);
    {rw, rd, as, br, bn, mw, mr, jp, lk, zx, un, ill} = '0;
    sz = 2'd0;
    if (op == 0) begin rw = 1; rd = 1; end
    else if (op >= 8 && op <= 11) begin rw = 1; as = 1; end
    else if (op >= 12 && op <= 15) begin rw = 1; as = 1; zx = 1; end
    else if (op == 32 || op == 33 || op == 35 || op == 36 || op == 37) begin
      rw = 1; as = 1; mr = 1;
      sz = (op % 4 == 0) ? 2'd0 : ((op % 4 == 1) ? 2'd1 : 2'd2);
      un = (op >= 36);
    end
    else if (op == 40 || op == 41 || op == 43) begin
      as = 1; mw = 1;
      sz = (op % 4 == 0) ? 2'd0 : ((op % 4 == 1) ? 2'd1 : 2'd2);
    end
    else if (op == 4) br = 1;
    else if (op == 5) begin br = 1; bn = 1; end
    else if (op == 2) jp = 1;
    else if (op == 3) begin jp = 1; lk = 1; rw = 1; end
    else ill = 1;
    e.ctrl    = {rw, rd, as, br, bn, mw, mr, jp, lk, zx, sz, un};
    e.illegal = ill;
    e.pc      = pc;
    e.instr   = instr;
    return e;
  endfunction

  // Advance one clock and update the model with what the DUT must have accepted/released
  task automatic step();
    bit   push;
    bit   pop;
    exp_t e;
    push = bus.in_valid && (q.size() < DEPTH);
    pop  = bus.out_ready && (q.size() > 0);
    e    = ref_dec(bus.in_instr, bus.in_pc);
    @(posedge clk);
    #1;
    if (bus.flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(e);
        if (e.illegal && ref_ill < 255) ref_ill++;
      end
    end
  endtask

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
  endtask

  task automatic drain();
    idle_inputs();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", bus.in_ready); end
    total++; if (bus.out_ctrl !== 13'h0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0 || bus.out_illegal !== 1'b0) begin
      bad++; $display("FAIL reset_head ctrl=%h pc=%h instr=%h ill=%0b want all 0", bus.out_ctrl, bus.out_pc, bus.out_instr, bus.out_illegal);
    end
    total++; if (bus.ill_cnt !== 8'd0) begin bad++; $display("FAIL reset_ill_cnt got=%0d want=0", bus.ill_cnt); end
    $display("reset checked");
  endtask

  task automatic test_lw();
    drain();
    bus.in_valid = 1'b1; bus.in_instr = 32'h8C88_0004; bus.in_pc = 32'h100; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL lw_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_ctrl !== 13'b1010001000100) begin bad++; $display("FAIL lw_ctrl got=%b want=%b", bus.out_ctrl, 13'b1010001000100); end
    total++; if (bus.out_pc !== 32'h100) begin bad++; $display("FAIL lw_pc got=%h want=100", bus.out_pc); end
    $display("push LW pc=%h ctrl=%b", bus.out_pc, bus.out_ctrl);
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lw_pop_valid got=%0b want=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    drain();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_instr = 32'h34A5_0001; bus.in_pc = 32'h200; step();
    bus.in_instr = 32'h14A0_FFFE; bus.in_pc = 32'h204; step();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b want=0", bus.in_ready); end
    bus.in_instr = 32'h20A5_0001; bus.in_pc = 32'h208; step();
    total++; if (bus.out_ctrl !== 13'b1010000001000 || bus.out_pc !== 32'h200) begin
      bad++; $display("FAIL ori_head ctrl=%b pc=%h want ctrl=%b pc=200", bus.out_ctrl, bus.out_pc, 13'b1010000001000);
    end
    $display("head ORI pc=%h ctrl=%b", bus.out_pc, bus.out_ctrl);
    // Full with pop and offer: pop only, count 2 -> 1
    bus.out_ready = 1'b1; step();
    total++; if (bus.out_ctrl !== 13'b0001100000000 || bus.out_pc !== 32'h204) begin
      bad++; $display("FAIL bne_head ctrl=%b pc=%h want ctrl=%b pc=204", bus.out_ctrl, bus.out_pc, 13'b0001100000000);
    end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_pop_ready got=%0b want=1", bus.in_ready); end
    $display("head BNE pc=%h ctrl=%b", bus.out_pc, bus.out_ctrl);
    bus.out_ready = 1'b0; step();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL addi_accept_ready got=%0b want=0", bus.in_ready); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; step();
    total++; if (bus.out_ctrl !== 13'b1010000000000 || bus.out_pc !== 32'h208) begin
      bad++; $display("FAIL addi_head ctrl=%b pc=%h want ctrl=%b pc=208", bus.out_ctrl, bus.out_pc, 13'b1010000000000);
    end
    $display("head ADDI pc=%h ctrl=%b", bus.out_pc, bus.out_ctrl);
  endtask

  task automatic test_stream();
    drain();
    bus.in_valid = 1'b1; bus.in_instr = 32'h0000_0020; bus.in_pc = 32'h300; step();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_instr = {6'b001000, 26'($urandom)};
      bus.in_pc    = 32'h304 + 32'(4 * i);
      step();
      total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_pc !== 32'h304 + 32'(4 * i)) begin
        bad++; $display("FAIL stream_%0d valid=%0b ready=%0b pc=%h want 1 1 %h", i, bus.out_valid, bus.in_ready, bus.out_pc, 32'h304 + 32'(4 * i));
      end
      $display("stream %0d head pc=%h", i, bus.out_pc);
    end
  endtask

  task automatic test_flush();
    drain();
    bus.in_valid = 1'b1; bus.in_instr = 32'h0000_0020; bus.in_pc = 32'h400; step();
    bus.in_instr = 32'h20A5_0001; bus.in_pc = 32'h404; bus.out_ready = 1'b1; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_ctrl !== 13'h0 || bus.out_pc !== 32'h0) begin
      bad++; $display("FAIL flush_state valid=%0b ready=%0b ctrl=%h pc=%h want 0 1 0 0", bus.out_valid, bus.in_ready, bus.out_ctrl, bus.out_pc);
    end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_lost got=%0b want=0", bus.out_valid); end
    $display("flush done");
  endtask

  task automatic test_random();
    logic [5:0] pool [16] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd9, 6'd10, 6'd13, 6'd15,
                              6'd32, 6'd36, 6'd37, 6'd41, 6'd43, 6'd63, 6'd34};
    exp_t h;
    bit   ne;
    drain();
    for (int i = 0; i < 400; i++) begin
      bus.flush     = ($urandom_range(0, 24) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_instr  = {pool[$urandom_range(0, 15)], 26'($urandom)};
      if (bus.flush) bus.in_instr = 32'h20A5_0001;
      bus.in_pc     = $urandom;
      if (bus.out_ready && q.size() > 0) $display("pop pc=%h instr=%h", q[0].pc, q[0].instr);
      step();
      ne = (q.size() != 0);
      h  = ne ? q[0] : '0;
      total++; if (bus.out_valid !== ne) begin bad++; $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", i, bus.out_valid, ne); end
      total++; if (bus.in_ready !== (q.size() < DEPTH)) begin bad++; $display("FAIL rand_ready cyc=%0d got=%0b want=%0b", i, bus.in_ready, q.size() < DEPTH); end
      total++; if (bus.out_ctrl !== h.ctrl) begin bad++; $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", i, bus.out_ctrl, h.ctrl); end
      total++; if (bus.out_pc !== h.pc || bus.out_instr !== h.instr) begin
        bad++; $display("FAIL rand_pc_instr cyc=%0d got=%h/%h want=%h/%h", i, bus.out_pc, bus.out_instr, h.pc, h.instr);
      end
      total++; if (bus.out_illegal !== h.illegal) begin bad++; $display("FAIL rand_illegal cyc=%0d got=%0b want=%0b", i, bus.out_illegal, h.illegal); end
      total++; if (bus.ill_cnt !== (CNT_EN ? 8'(ref_ill) : 8'd0)) begin
        bad++; $display("FAIL rand_ill_cnt cyc=%0d got=%0d want=%0d", i, bus.ill_cnt, CNT_EN ? ref_ill : 0);
      end
    end
  endtask

  task automatic test_illegal_sat();
    drain();
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_instr = 32'hFC00_0000; bus.in_pc = 32'h500;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 0) begin
        total++; if (bus.out_illegal !== 1'b1 || bus.out_ctrl !== 13'h0) begin
          bad++; $display("FAIL ill_head illegal=%0b ctrl=%h want 1 0", bus.out_illegal, bus.out_ctrl);
        end
      end
    end
    bus.in_valid = 1'b0;
    total++; if (bus.ill_cnt !== (CNT_EN ? 8'd255 : 8'd0)) begin
      bad++; $display("FAIL ill_sat got=%0d want=%0d", bus.ill_cnt, CNT_EN ? 255 : 0);
    end
    $display("illegal x300 ill_cnt=%0d", bus.ill_cnt);
  endtask

  task automatic test_async_reset();
    drain();
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0000_0020; bus.in_pc = 32'h600; step();
    bus.in_instr = 32'hFC00_0000; bus.in_pc = 32'h604; step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_ctrl !== 13'h0 || bus.out_instr !== 32'h0) begin
      bad++; $display("FAIL async_rst valid=%0b ready=%0b ctrl=%h instr=%h want 0 1 0 0", bus.out_valid, bus.in_ready, bus.out_ctrl, bus.out_instr);
    end
    total++; if (bus.ill_cnt !== 8'd0) begin bad++; $display("FAIL async_rst_ill got=%0d want=0", bus.ill_cnt); end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    ref_ill = 0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h0C00_0010; bus.in_pc = 32'h700;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_pc !== 32'h700 || bus.out_ctrl !== 13'b1000000110000) begin
      bad++; $display("FAIL post_rst_jal pc=%h ctrl=%b want 700 %b", bus.out_pc, bus.out_ctrl, 13'b1000000110000);
    end
    $display("async reset done, JAL pc=%h", bus.out_pc);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    ref_ill = 0;
    rst     = 1'b1;
    idle_inputs();
    #23 rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_backpressure();
    test_stream();
    test_flush();
    test_random();
    test_illegal_sat();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maindec_q.md
Name: maindec_q

Overview:
- Registered, queued successor to the combinational main decoder. It decodes each accepted 32-bit MIPS instruction into an extended control bundle and stores it with its PC in a DEPTH-entry FIFO.
- Bundle adds link, branch polarity, memory size/sign and illegal-op flag; decouples fetch from decode with valid/ready on both sides.
- Sits between the IF/ID register and the ID-stage register file/hazard unit.

Parameters:
- DEPTH, 2, queue entries; power of 2, >= 2
- PC_W, 32, width of PC carried alongside each instruction
- ILL_CNT_W, 8, width of illegal-opcode counter (used only with feature enabled)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous queue clear (branch mispredict/exception)
- in_valid  input  1  instruction offered
- in_ready  output  1  queue can accept (= not full)
- in_instr  input  32  instruction word
- in_pc  input  PC_W  PC of in_instr
- out_valid  output  1  head entry valid (= not empty)
- out_ready  input  1  consumer takes head
- out_ctrl  output  CTRL_W  decoded bundle of head entry
- out_pc  output  PC_W  PC of head entry
- out_instr  output  32  raw instruction of head entry
- out_illegal  output  1  head opcode unrecognised
- ill_cnt  output  ILL_CNT_W  illegal count (0 when feature off)

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high (clk, rst). Reset clears wr_ptr, rd_ptr, count, ill_cnt: out_valid=0, in_ready=1, out_ctrl/out_pc/out_instr/out_illegal=0. Storage array is not reset.
- Decode is combinational on in_instr; the result is written with pc/instr on push (push = in_valid & in_ready).
- Latency: accepted at edge N, visible at out_valid after edge N; no input-to-output combinational bypass.
- out_ctrl, out_pc, out_instr, out_illegal are forced to 0 while empty.
- Pop = out_valid & out_ready; head advances at edge.
- Push and pop in the same cycle: count unchanged, both pointers advance. Valid when 0 < count < DEPTH. When full, in_ready=0, so there is no push even if pop occurs (no ready-through-pop).
- Pointers wrap modulo DEPTH. count has log2(DEPTH)+1 bits.
- flush: next edge sets pointers/count to 0. Any push/pop that cycle is discarded. flush has priority over push/pop. rst overrides all.
- CTRL_W=13 bundle, MSB first: regwrite, regdst, alusrc, branch, bne, memwrite, memtoreg, jump, link, zext, mem_size[1:0] (0 byte, 1 half, 2 word), mem_uns.
- Opcode map (others: illegal=1, bundle all 0):
  - RTYPE 000000: regwrite, regdst
  - ADDI/ADDIU/SLTI/SLTIU 0010xx: regwrite, alusrc
  - ANDI/ORI/XORI/LUI 0011xx: regwrite, alusrc, zext
  - LB/LH/LW/LBU/LHU 100000/100001/100011/100100/100101: regwrite, alusrc, memtoreg, size by op[1:0], mem_uns=op[2]
  - SB/SH/SW 101000/101001/101011: alusrc, memwrite, size
  - BEQ 000100: branch; BNE 000101: branch, bne
  - J 000010: jump; JAL 000011: jump, link, regwrite

Optional Feature:
- MAINDEC_ILLEGAL_CNT_EN defined: ill_cnt increments on each push whose opcode is illegal and saturates at all-ones. It is cleared only by rst, not by flush.
- Undefined: ill_cnt tied to 0 and no counter register exists.

Decomposition:
- Shared package/header: opcode constants (OP_*), CTRL_W, bundle bit-index constants, MEM_SIZE_* encodings.
- One sub-module: maindec_q_dec (pure combinational instr -> {ctrl, illegal}). The FIFO and counter stay in the top.

Test Plan:
- Reset mid-stream: rst pulsed asynchronously with 2 entries queued -> out_valid=0, in_ready=1, out_ctrl=0 immediately, before the next edge.
- Push LW 0x8C880004, pc 0x100, out_ready=1 -> next cycle out_valid=1, out_ctrl=13'b1010001000100, out_pc=0x100.
- DEPTH=2, out_ready=0, push ORI, BNE, then offer ADDI -> in_ready=0 after 2 pushes. Heads ORI (zext=1), then BNE (branch=1, bne=1) after pop. ADDI accepted only after first pop.
- Full queue, simultaneous pop and in_valid -> no push that cycle, count 2->1. Streaming at count=1 with push+pop every cycle for 10 cycles -> order preserved and pointers wrap.
- flush asserted with push and pop both active at count=1 -> count=0 next cycle, out_valid=0, pushed instr lost.
- Opcode 0x3F pushed 300 times with MAINDEC_ILLEGAL_CNT_EN -> out_illegal=1, ill_cnt saturates at 255. Without macro, ill_cnt=0.
